regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-back register file. It consumes the stage-three pipeline outputs (S3_ALUOUT, S3_WS, S3_WE) and commits them to a 32-entry architectural register file.
- It provides two combinational read ports to the decode/operand-fetch stage. A write-to-read bypass covers the write-back/decode overlap.
- A saturating commit counter supports debug and verification.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register select width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 hardwired to zero and writes to it discarded; 0 = register 0 is ordinary
- CNT_W, 16, width of the commit counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- S3_ALUOUT  input  DATA_W  write-back data from stage three
- S3_WS  input  ADDR_W  write-back destination select
- S3_WE  input  1  write-back enable
- ReadSelect1  input  ADDR_W  read port 1 select
- ReadSelect2  input  ADDR_W  read port 2 select
- ReadData1  output  DATA_W  read port 1 data (combinational)
- ReadData2  output  DATA_W  read port 2 data (combinational)
- WriteCount  output  CNT_W  number of committed writes since reset, saturating

Behaviour:
- Reset: synchronous, active-high; clock clk. On a rising edge with reset=1, all 2**ADDR_W registers clear to 0 and WriteCount clears to 0.
- Reset priority: reset beats a simultaneous S3_WE=1, so no write commits in that cycle.
- Effective write: we_eff = S3_WE and not (ZERO_REG=1 and S3_WS=0).
- Commit: on a rising edge with reset=0 and we_eff=1, regs[S3_WS] <= S3_ALUOUT, with a latency of 1 edge.
  - S3_WE=0: no state change.
  - Suppressed write to r0 (ZERO_REG=1): no state change, counter not incremented.
- Read, per port n: ReadDatan is purely combinational.
  - If ZERO_REG=1 and ReadSelectn=0: output 0, regardless of bypass.
  - Else, if we_eff=1 and S3_WS=ReadSelectn: output S3_ALUOUT (bypass; the same-cycle write is visible immediately).
  - Else: output regs[ReadSelectn].
- Both ports are independent. Both may select the same register, and both may bypass in the same cycle.
- Reset outputs: reads are combinational, so they never return an indeterminate value after reset.
  - During a reset cycle, reads still reflect the current register contents plus the bypass.
  - After the reset edge, every read returns 0 until a write commits.
- WriteCount: increments by 1 on every committed write (we_eff=1, reset=0). It saturates at 2**CNT_W-1 and never wraps.
- Rewrites: repeated writes to the same register in consecutive cycles follow last-write-wins. Each one counts.
- Undefined inputs: X on S3_WE while reset=0 is a protocol violation. The bench flags it with an assertion; the RTL need not handle it.
- No other handshake applies: every stage-three output presented with S3_WE=1 commits in that cycle, and there is no back-pressure.

Test Plan:
- Reset/readback:
  - Stimulus: write r5=0xDEADBEEF, then assert reset for 1 cycle, then read r5 on both ports.
  - Required: 0x00000000 on both ports, WriteCount=0.
- Write then read:
  - Stimulus: S3_WE=1, S3_WS=7, S3_ALUOUT=0x12345678 for 1 cycle; next cycle S3_WE=0, ReadSelect1=7.
  - Required: ReadData1=0x12345678, WriteCount=1.
- Bypass:
  - Stimulus: regs[3]=0x11, then present S3_WE=1, S3_WS=3, S3_ALUOUT=0x22 with ReadSelect1=ReadSelect2=3 in the same cycle.
  - Required: both ports read 0x22 before the edge, and regs[3]=0x22 after it.
- Zero register (ZERO_REG=1):
  - Stimulus: S3_WE=1, S3_WS=0, S3_ALUOUT=0xFFFFFFFF, with ReadSelect1=0.
  - Required: ReadData1=0 in the same cycle and the next, WriteCount unchanged.
  - With ZERO_REG=0, the same stimulus must read back 0xFFFFFFFF and increment WriteCount.
- Reset vs write collision:
  - Stimulus: reset=1 and S3_WE=1, S3_WS=9, S3_ALUOUT=0xAA on the same edge.
  - Required: regs[9]=0 afterwards, WriteCount=0.
- Counter saturation (CNT_W=4):
  - Stimulus: 20 consecutive writes to r1 with values 1..20.
  - Required: WriteCount stops at 15, r1 reads 20.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Write-back / read-port bundle for the architectural register file.
// master = pipeline side, slave = register file.
interface regfile_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] S3_ALUOUT;
  logic [ADDR_W-1:0] S3_WS;
  logic              S3_WE;
  logic [ADDR_W-1:0] ReadSelect1;
  logic [ADDR_W-1:0] ReadSelect2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [CNT_W-1:0]  WriteCount;

  modport master (
    output S3_ALUOUT, S3_WS, S3_WE,
    output ReadSelect1, ReadSelect2,
    input  ReadData1, ReadData2, WriteCount
  );

  modport slave (
    input  S3_ALUOUT, S3_WS, S3_WE,
    input  ReadSelect1, ReadSelect2,
    output ReadData1, ReadData2, WriteCount
  );
endinterface

// File: rtl/regfile_writeback.sv
// Architectural register file fed by stage three, with write-to-read
// bypass on both read ports and a saturating commit counter.
module regfile_writeback #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  regfile_writeback_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              we_eff;
  logic              ws_zero;

  // Writes to r0 are dropped when r0 is hardwired.
  always_comb begin
    ws_zero = (bus.S3_WS == '0);
    we_eff  = bus.S3_WE && !((ZERO_REG != 0) && ws_zero);
  end

  // Register array: clear on reset, else commit the effective write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_eff) begin
      regs_q[bus.S3_WS] <= bus.S3_ALUOUT;
    end
  end

  // Commit counter next state, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (we_eff && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Commit counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read port 1: zero reg, then bypass, then array.
  always_comb begin
    bus.ReadData1 = regs_q[bus.ReadSelect1];
    if ((ZERO_REG != 0) && (bus.ReadSelect1 == '0)) begin
      bus.ReadData1 = '0;
    end else if (we_eff && (bus.S3_WS == bus.ReadSelect1)) begin
      bus.ReadData1 = bus.S3_ALUOUT;
    end
  end

  // Read port 2: zero reg, then bypass, then array.
  always_comb begin
    bus.ReadData2 = regs_q[bus.ReadSelect2];
    if ((ZERO_REG != 0) && (bus.ReadSelect2 == '0)) begin
      bus.ReadData2 = '0;
    end else if (we_eff && (bus.S3_WS == bus.ReadSelect2)) begin
      bus.ReadData2 = bus.S3_ALUOUT;
    end
  end

  assign bus.WriteCount = cnt_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: one r0-hardwired instance
// with a 16-bit counter, one plain-r0 instance with a 4-bit counter.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_writeback_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) b0();
  regfile_writeback_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  b1();

  regfile_writeback #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CNT_W(16)
  ) dut0 (.clk(clk), .reset(rst), .bus(b0));

  regfile_writeback #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .CNT_W(4)
  ) dut1 (.clk(clk), .reset(rst), .bus(b1));

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int n_cmp = 0;
  int n_fail = 0;

  // Protocol check: write enable must be known outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(b0.S3_WE) && !$isunknown(b1.S3_WE))
        else $error("S3_WE unknown outside reset");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic idle();
    b0.S3_WE = 1'b0; b0.S3_WS = '0; b0.S3_ALUOUT = '0;
    b0.ReadSelect1 = '0; b0.ReadSelect2 = '0;
    b1.S3_WE = 1'b0; b1.S3_WS = '0; b1.S3_ALUOUT = '0;
    b1.ReadSelect1 = '0; b1.ReadSelect2 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b0.ReadSelect1 = 5'd5; b0.ReadSelect2 = 5'd5;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL rst_rd1 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL rst_cnt got %0d want %0d", b0.WriteCount, exp);
    end
    b0.S3_WE = 1'b1; b0.S3_WS = 5'd5; b0.S3_ALUOUT = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    b0.S3_WE = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL pre_rst_r5 got %h want %h", b0.ReadData1, exp);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL rst_r5_p1 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData2 !== exp) begin
      n_fail++; $display("FAIL rst_r5_p2 got %h want %h", b0.ReadData2, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL rst_cnt2 got %0d want %0d", b0.WriteCount, exp);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    b0.S3_WE = 1'b1; b0.S3_WS = 5'd7; b0.S3_ALUOUT = 32'h12345678;
    b0.ReadSelect1 = 5'd9;
    exp_q.push_back(32'h12345678); exp_q.push_back(32'd1);
    @(negedge clk);
    b0.S3_WE = 1'b0; b0.ReadSelect1 = 5'd7;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL wr_rd got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL wr_cnt got %0d want %0d", b0.WriteCount, exp);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    b0.S3_WE = 1'b1; b0.S3_WS = 5'd3; b0.S3_ALUOUT = 32'h11;
    @(negedge clk);
    b0.S3_WE = 1'b0; b0.ReadSelect1 = 5'd3; b0.ReadSelect2 = 5'd3;
    exp_q.push_back(32'h11);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL byp_old got %h want %h", b0.ReadData1, exp);
    end
    b0.S3_WE = 1'b1; b0.S3_ALUOUT = 32'h22;
    exp_q.push_back(32'h22); exp_q.push_back(32'h22);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL byp_p1 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData2 !== exp) begin
      n_fail++; $display("FAIL byp_p2 got %h want %h", b0.ReadData2, exp);
    end
    exp_q.push_back(32'h22); exp_q.push_back(32'd3);
    @(negedge clk);
    b0.S3_WE = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData2 !== exp) begin
      n_fail++; $display("FAIL byp_commit got %h want %h", b0.ReadData2, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL byp_cnt got %0d want %0d", b0.WriteCount, exp);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    b0.S3_WE = 1'b1; b0.S3_WS = 5'd0; b0.S3_ALUOUT = 32'hFFFFFFFF;
    b0.ReadSelect1 = 5'd0;
    b1.S3_WE = 1'b1; b1.S3_WS = 5'd0; b1.S3_ALUOUT = 32'hFFFFFFFF;
    b1.ReadSelect1 = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFFFFFF);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL z1_same got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b1.ReadData1 !== exp) begin
      n_fail++; $display("FAIL z0_same got %h want %h", b1.ReadData1, exp);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'd3);
    exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'd1);
    @(negedge clk);
    b0.S3_WE = 1'b0; b1.S3_WE = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL z1_next got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL z1_cnt got %0d want %0d", b0.WriteCount, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b1.ReadData1 !== exp) begin
      n_fail++; $display("FAIL z0_next got %h want %h", b1.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b1.WriteCount !== exp[3:0]) begin
      n_fail++; $display("FAIL z0_cnt got %0d want %0d", b1.WriteCount, exp);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    rst = 1'b1;
    b0.S3_WE = 1'b1; b0.S3_WS = 5'd9; b0.S3_ALUOUT = 32'hAA;
    b0.ReadSelect1 = 5'd9;
    exp_q.push_back(32'hAA);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL col_byp got %h want %h", b0.ReadData1, exp);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    rst = 1'b0; b0.S3_WE = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL col_r9 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL col_cnt got %0d want %0d", b0.WriteCount, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b1.WriteCount !== exp[3:0]) begin
      n_fail++; $display("FAIL col_cnt1 got %0d want %0d", b1.WriteCount, exp);
    end
  endtask

  task automatic test_saturation();
    b1.ReadSelect1 = 5'd1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      b1.S3_WE = 1'b1; b1.S3_WS = 5'd1; b1.S3_ALUOUT = 32'(i);
      exp_q.push_back((i > 15) ? 32'd15 : 32'(i));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front(); n_cmp++;
      if (b1.WriteCount !== exp[3:0]) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d] got %0d want %0d", i, b1.WriteCount, exp);
      end
    end
    @(negedge clk);
    b1.S3_WE = 1'b0;
    exp_q.push_back(32'd20);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b1.ReadData1 !== exp) begin
      n_fail++; $display("FAIL sat_r1 got %0d want %0d", b1.ReadData1, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      b0.S3_WE = 1'b1; b0.S3_WS = 5'd4; b0.S3_ALUOUT = 32'(i);
    end
    exp_q.push_back(32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v[i] = $urandom;
      b0.S3_WE = 1'b1; b0.S3_WS = 5'(11 + i); b0.S3_ALUOUT = v[i];
      exp_q.push_back(v[i]);
    end
    exp_q.push_back(32'd7);
    @(negedge clk);
    b0.S3_WE = 1'b0;
    b0.ReadSelect1 = 5'd4; b0.ReadSelect2 = 5'd11;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL b2b_r4 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData2 !== exp) begin
      n_fail++; $display("FAIL b2b_r11 got %h want %h", b0.ReadData2, exp);
    end
    b0.ReadSelect1 = 5'd12; b0.ReadSelect2 = 5'd13;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL b2b_r12 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData2 !== exp) begin
      n_fail++; $display("FAIL b2b_r13 got %h want %h", b0.ReadData2, exp);
    end
    b0.ReadSelect1 = 5'd14;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.ReadData1 !== exp) begin
      n_fail++; $display("FAIL b2b_r14 got %h want %h", b0.ReadData1, exp);
    end
    exp = exp_q.pop_front(); n_cmp++;
    if (b0.WriteCount !== exp[15:0]) begin
      n_fail++; $display("FAIL b2b_cnt got %0d want %0d", b0.WriteCount, exp);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_collision();
    test_saturation();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_left got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
